result_digit_emitter: RTL and testbench
=======================================

RESULT_DIGIT_EMITTER -- requirements
Module: result_digit_emitter

Interface
REQ-001 The module SHALL have parameter ASCII_OUT, default 1, meaning 1 = digit output as ASCII ('0'+d) and 0 = raw BCD in bits [3:0] with bits [7:4] = 0.
REQ-002 The module SHALL have port clk, input, 1 bit, the single system clock; all logic on posedge clk.
REQ-003 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The module SHALL have port in, input, 8 bits, unsigned binary result to convert (0..255).
REQ-005 The module SHALL have port start, input, 1 bit, request to convert in; sampled only in IDLE.
REQ-006 The module SHALL have port out_ready, input, 1 bit, downstream (transmitter/display) accepts digit.
REQ-007 The module SHALL have port out, output, 8 bits, current digit, most significant first.
REQ-008 The module SHALL have port out_valid, output, 1 bit, out holds a digit awaiting acceptance.
REQ-009 The module SHALL have port out_last, output, 1 bit, current digit is the ones digit.
REQ-010 The module SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-011 The module SHALL have port done, output, 1 bit, one-cycle pulse after the last digit is accepted.

Function
REQ-012 The module SHALL implement states IDLE, CONV, EMIT_H, EMIT_T, EMIT_O, DONE.
REQ-013 In IDLE with start=1, the module SHALL latch in into an 8-bit remainder, clear the hundreds and tens counters, and go to CONV; start SHALL be ignored in every other state.
REQ-014 In CONV, the module SHALL perform at most one subtraction per cycle: if rem>=100, rem-=100 and hund+=1; else if rem>=10, rem-=10 and tens+=1; else ones=rem[3:0] and leave CONV.
REQ-015 CONV SHALL last hund+tens+1 cycles; out_valid SHALL first rise hund+tens+2 edges after the edge that samples start (255 -> 9, 0 -> 2).
REQ-016 On leaving CONV, the module SHALL go to EMIT_H if hund!=0, else EMIT_T if tens!=0, else EMIT_O (leading-zero suppression; a zero tens digit after a nonzero hundreds digit SHALL still be emitted).
REQ-017 In EMIT_x, out_valid SHALL be 1 and out SHALL hold the digit, stable until the cycle in which out_valid&out_ready=1.
REQ-018 On transfer, the module SHALL advance EMIT_H->EMIT_T->EMIT_O->DONE; with out_ready held high, one digit SHALL transfer per cycle.
REQ-019 out_last SHALL be 1 only in EMIT_O.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the module SHALL then return to IDLE; start SHALL be accepted on the next cycle.
REQ-021 Value 0 SHALL emit exactly one digit, '0'.
REQ-022 Counters SHALL be 4 bits; hund<=2 and tens<=9 by construction, with no overflow path.
REQ-023 out SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst=1 at any posedge SHALL force IDLE and clear rem, hund, tens, ones, out, out_valid, out_last, busy, and done, including mid-CONV or mid-EMIT; no partial digit SHALL be emitted afterwards.
REQ-025 rst SHALL take priority over start and out_ready in the same cycle.

Structure
REQ-026 The shared calculator package SHALL hold the state encoding constants, ASCII_ZERO = 8'h30, and the constants 10 and 100.
REQ-027 One sub-module, dec_digit_split (the CONV subtract step and counters), is natural; the emit FSM and output register SHALL stay in result_digit_emitter.

Verification
REQ-028 in=255, start pulse, out_ready=1 -> out '2','5','5' (8'h32,8'h35,8'h35) on consecutive cycles; out_valid first rises 9 edges after start; out_last only on the third digit; done one cycle later.
REQ-029 in=0 -> single digit 8'h30 with out_last=1; in=7 -> single 8'h37; in=105 -> '1','0','5'.
REQ-030 in=42, out_ready low for 5 cycles then high -> out holds 8'h34 with out_valid=1 throughout the stall, then '4','2'.
REQ-031 start pulsed with in=99 while busy (mid-conversion of 200) -> emits '2','0','0' only; the second start is ignored.
REQ-032 rst asserted mid-EMIT_T of 123 -> next cycle all outputs 0 and busy=0; a fresh start with in=9 emits only '9'.
REQ-033 ASCII_OUT=0, in=58 -> out 8'h05 then 8'h08.

Source files
------------

// File: rtl/result_digit_emitter_pkg.sv
// Shared definitions for the binary-to-decimal digit emitter.
// State encoding, decimal constants and small digit helpers.
package result_digit_emitter_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONV   = 3'd1,
    S_EMIT_H = 3'd2,
    S_EMIT_T = 3'd3,
    S_EMIT_O = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] DEC_TEN    = 8'd10;
  localparam logic [7:0] DEC_HUND   = 8'd100;

  function automatic state_t emit_next(input state_t s);
    unique case (s)
      S_EMIT_H: emit_next = S_EMIT_T;
      S_EMIT_T: emit_next = S_EMIT_O;
      default:  emit_next = S_DONE;
    endcase
  endfunction

  function automatic logic [3:0] pick_digit(
    input state_t     s,
    input logic [3:0] h,
    input logic [3:0] t,
    input logic [3:0] o
  );
    unique case (s)
      S_EMIT_H: pick_digit = h;
      S_EMIT_T: pick_digit = t;
      default:  pick_digit = o;
    endcase
  endfunction

  function automatic logic [7:0] digit_char(
    input logic [3:0] d,
    input logic       ascii
  );
    digit_char = ascii ? ASCII_ZERO + {4'd0, d} : {4'd0, d};
  endfunction

endpackage

// File: rtl/result_digit_emitter_split.sv
// Repeated-subtraction split of an 8-bit value into decimal digits.
// One subtraction per step; fin flags that the remainder is the ones digit.
module dec_digit_split
  import result_digit_emitter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       fin
);

  logic [7:0] rem_q, rem_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  always_comb begin
    rem_d  = rem_q;
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      rem_d  = load_val;
      hund_d = 4'd0;
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (step) begin
      if (rem_q >= DEC_HUND) begin
        rem_d  = rem_q - DEC_HUND;
        hund_d = hund_q + 4'd1;
      end else if (rem_q >= DEC_TEN) begin
        rem_d  = rem_q - DEC_TEN;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = rem_q[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= 8'd0;
      hund_q <= 4'd0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      rem_q  <= rem_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign hund = hund_q;
  assign tens = tens_q;
  assign ones = ones_q;
  assign fin  = rem_q < DEC_TEN;

endmodule

// File: rtl/result_digit_emitter.sv
// Converts an 8-bit result to decimal digits, MSD first, over a
// valid/ready link with leading-zero suppression.
module result_digit_emitter
  import result_digit_emitter_pkg::*;
#(
  parameter int ASCII_OUT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       start,
  input  logic       out_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam logic ASC = (ASCII_OUT != 0);

  state_t     state_q, state_d, nxt;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       load, step, fin;
  logic [3:0] hund, tens, ones;

  dec_digit_split u_split (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (in),
    .step     (step),
    .hund     (hund),
    .tens     (tens),
    .ones     (ones),
    .fin      (fin)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    load        = 1'b0;
    step        = 1'b0;
    nxt         = emit_next(state_q);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        step = 1'b1;
        if (fin) begin
          if (hund != 4'd0)      state_d = S_EMIT_H;
          else if (tens != 4'd0) state_d = S_EMIT_T;
          else                   state_d = S_EMIT_O;
        end
      end
      S_EMIT_H, S_EMIT_T, S_EMIT_O: begin
        // first cycle in an emit state loads the register; later
        // transfers preload the following digit to keep full rate
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_last_d  = (state_q == S_EMIT_O);
          out_d = digit_char(pick_digit(state_q, hund, tens, ones), ASC);
        end else if (out_ready) begin
          state_d     = nxt;
          out_valid_d = (nxt != S_DONE);
          out_last_d  = (nxt == S_EMIT_O);
          out_d = (nxt == S_DONE) ? 8'd0 :
                  digit_char(pick_digit(nxt, hund, tens, ones), ASC);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_result_digit_emitter.sv
// Randomized bench for result_digit_emitter (ASCII and raw BCD builds)
// against a plain-arithmetic decimal reference model.
module tb_result_digit_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       start;
  logic       out_ready;
  logic [7:0] out_a, out_r;
  logic       valid_a, valid_r;
  logic       last_a, last_r;
  logic       busy_a, busy_r;
  logic       done_a, done_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_digit_emitter #(.ASCII_OUT(1)) dut_a (
    .clk(clk), .rst(rst), .in(in), .start(start),
    .out_ready(out_ready), .out(out_a), .out_valid(valid_a),
    .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  result_digit_emitter #(.ASCII_OUT(0)) dut_r (
    .clk(clk), .rst(rst), .in(in), .start(start),
    .out_ready(out_ready), .out(out_r), .out_valid(valid_r),
    .out_last(last_r), .busy(busy_r), .done(done_r)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of v without leading zeros, and the
  // number of subtraction steps the conversion takes.
  task automatic ref_digits(input int v, output int d[$],
                            output int steps);
    int h, t, o;
    h = v / 100;
    t = (v % 100) / 10;
    o = v % 10;
    d = {};
    if (h != 0) d.push_back(h);
    if (h != 0 || t != 0) d.push_back(t);
    d.push_back(o);
    steps = h + t;
  endtask

  task automatic convert(input int v, input int pct, input int stall,
                         input int restart_at);
    int d[$];
    int steps, edges, first, idx, n;
    logic r, hold;
    logic [7:0] held;
    ref_digits(v, d, steps);
    n = d.size();
    @(negedge clk);
    in = v[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy_a, 1'b1);
    edges = 0;
    first = -1;
    idx = 0;
    hold = 1'b0;
    held = 8'd0;
    while (idx < n && edges < 400) begin
      if (edges == restart_at) begin
        in = 8'd99;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (valid_a && first < 0) begin
        first = edges;
        chk("first_valid_lat", first, steps + 2);
      end
      if (!valid_a) begin
        checks++;
        if (out_a !== 8'd0 || out_r !== 8'd0) begin
          errors++;
          $display("FAIL idle_out: got %0h/%0h expected 0", out_a, out_r);
        end
      end
      if (hold) chk("stall_hold", {out_a, 7'd0, valid_a}, {held, 8'd1});
      r = ($urandom_range(99, 0) < pct);
      if (first >= 0 && edges - first < stall) r = 1'b0;
      out_ready = r;
      hold = valid_a && !r;
      held = out_a;
      if (valid_a && r) begin
        chk("digit_ascii", out_a, 8'h30 + d[idx]);
        chk("digit_raw", out_r, d[idx]);
        chk("out_last", last_a, (idx == n - 1));
        chk("valid_raw", valid_r, 1'b1);
        idx++;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    chk("digits_done", idx, n);
    chk("done_pulse", {done_a, valid_a, done_r}, 3'b101);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_clear", {done_a, busy_a, valid_a}, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    in = 8'd0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {out_a, valid_a, last_a, busy_a, done_a}, 12'd0);
    rst = 1'b0;

    convert(255, 100, 0, -1);
    convert(0, 100, 0, -1);
    convert(7, 100, 0, -1);
    convert(105, 100, 0, -1);
    convert(42, 100, 5, -1);
    convert(58, 100, 0, -1);
    convert(200, 100, 0, 2);
    convert(100, 60, 2, -1);
    convert(10, 60, 0, -1);

    // reset while the tens digit of 123 is on the link
    @(negedge clk);
    in = 8'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int guard = 0;
      while (!valid_a && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("rst_wait", guard < 50, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("tens_123", out_a, 8'h32);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst", {out_a, valid_a, last_a, busy_a, done_a}, 12'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {valid_a, busy_a}, 2'b00);
    end
    convert(9, 100, 0, -1);

    for (int i = 0; i < 30; i++) begin
      convert($urandom_range(255, 0), $urandom_range(100, 30),
              $urandom_range(3, 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
